// File: rtl/secuenciador_bandas_filtro_pkg.sv
// -----------------------------------------------------------------------------
// secuenciador_bandas_filtro_pkg
// Shared definitions for the three-band filter sequencer:
//   - band select codes driven on Sel_Muxes
//   - FSM state encodings
//   - default word width and settle length
//   - helper mapping a band index onto its select code
// -----------------------------------------------------------------------------
package secuenciador_bandas_filtro_pkg;

    localparam int WIDTH_DEFAULT  = 22;
    localparam int SETTLE_DEFAULT = 2;

    localparam logic [1:0] SEL_ALTAS  = 2'b00;
    localparam logic [1:0] SEL_MEDIAS = 2'b01;
    localparam logic [1:0] SEL_BAJAS  = 2'b10;

    // Index of the last band in a pass (altas=0, medias=1, bajas=2).
    localparam logic [1:0] BAND_LAST = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETTLE = 2'b01,
        ST_COMMIT = 2'b10
    } estado_t;

    // Band index to mux select code; 2'b11 can never be produced.
    function automatic logic [1:0] sel_for_band(input logic [1:0] band);
        case (band)
            2'd0:    sel_for_band = SEL_ALTAS;
            2'd1:    sel_for_band = SEL_MEDIAS;
            default: sel_for_band = SEL_BAJAS;
        endcase
    endfunction

endpackage

// File: rtl/contador_asentamiento.sv
// -----------------------------------------------------------------------------
// contador_asentamiento
// Load / count-down settle counter. A load presets the count so that 'done'
// rises after exactly SettleCycles cycles in the settle phase; the counter then
// rests at zero until the next load.
// Ports:
//   clk   in  1  clock, rising edge
//   rst   in  1  asynchronous active-high clear
//   load  in  1  preset the count for a fresh settle window
//   dec   in  1  count down by one (ignored at zero)
//   done  out 1  count has reached zero
// -----------------------------------------------------------------------------
module contador_asentamiento #(
    parameter int SettleCycles = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic done
);

    localparam int CW = $clog2(SettleCycles + 1);
    // The first settle cycle sees the loaded value, so SettleCycles-1 decrements
    // bring the count to zero in the last settle cycle.
    localparam logic [CW-1:0] LOAD_VALUE = CW'(SettleCycles - 1);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= LOAD_VALUE;
        end else if (dec && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - CW'(1);
        end
    end

    assign done = (cnt_reg == '0);

endmodule

// File: rtl/secuenciador_bandas_filtro.sv
// -----------------------------------------------------------------------------
// secuenciador_bandas_filtro
// Control stage for a time-multiplexed three-band low-pass IIR datapath.
// A sample is latched onto uk, then the band select walks altas -> medias ->
// bajas. Each band gets SettleCycles cycles for the combinational filter path
// to settle followed by one COMMIT cycle in which that band's enable is high
// and filt_out is captured into the band's result register. After bajas the
// three results are announced with a one-cycle bands_valid pulse.
// Ports:
//   clk150kHz    in   1      clock, rising edge
//   reset        in   1      asynchronous active-high clear
//   sample_valid in   1      new sample strobe
//   adc_data     in   Width  signed sample
//   filt_out     in   Width  signed combinational filter output
//   ovr_clr      in   1      clears the overrun flag
//   uk           out  Width  held sample into the filter
//   Sel_Muxes    out  2      band select (00 altas, 01 medias, 10 bajas)
//   enable1..3   out  1      per-band state update strobes
//   band_altas/band_medias/band_bajas  out Width  committed band results
//   bands_valid  out  1      all three results refreshed
//   busy         out  1      pass in progress
//   overrun      out  1      sticky: a sample was dropped while busy
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module secuenciador_bandas_filtro
    import secuenciador_bandas_filtro_pkg::*;
#(
    parameter int Width        = WIDTH_DEFAULT,
    parameter int SettleCycles = SETTLE_DEFAULT
) (
    input  logic             clk150kHz,
    input  logic             reset,
    input  logic             sample_valid,
    input  logic [Width-1:0] adc_data,
    input  logic [Width-1:0] filt_out,
    input  logic             ovr_clr,
    output logic [Width-1:0] uk,
    output logic [1:0]       Sel_Muxes,
    output logic             enable1,
    output logic             enable2,
    output logic             enable3,
    output logic [Width-1:0] band_altas,
    output logic [Width-1:0] band_medias,
    output logic [Width-1:0] band_bajas,
    output logic             bands_valid,
    output logic             busy,
    output logic             overrun
);

    estado_t          estado_reg,      estado_next;
    logic [1:0]       band_reg,        band_next;
    logic [1:0]       sel_reg,         sel_next;
    logic [Width-1:0] uk_reg,          uk_next;
    logic [2:0]       en_reg,          en_next;
    logic             bands_valid_reg, bands_valid_next;
    logic             busy_reg,        busy_next;
    logic             overrun_reg,     overrun_next;

    logic [2:0]       cap_band;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_done;

    contador_asentamiento #(
        .SettleCycles(SettleCycles)
    ) u_contador (
        .clk  (clk150kHz),
        .rst  (reset),
        .load (cnt_load),
        .dec  (cnt_dec),
        .done (cnt_done)
    );

    always_ff @(posedge clk150kHz or posedge reset) begin
        if (reset) begin
            estado_reg      <= ST_IDLE;
            band_reg        <= 2'd0;
            sel_reg         <= SEL_ALTAS;
            uk_reg          <= '0;
            en_reg          <= '0;
            bands_valid_reg <= 1'b0;
            busy_reg        <= 1'b0;
            overrun_reg     <= 1'b0;
        end else begin
            estado_reg      <= estado_next;
            band_reg        <= band_next;
            sel_reg         <= sel_next;
            uk_reg          <= uk_next;
            en_reg          <= en_next;
            bands_valid_reg <= bands_valid_next;
            busy_reg        <= busy_next;
            overrun_reg     <= overrun_next;
        end
    end

    always_comb begin
        estado_next      = estado_reg;
        band_next        = band_reg;
        sel_next         = sel_reg;
        uk_next          = uk_reg;
        en_next          = '0;
        bands_valid_next = 1'b0;
        busy_next        = busy_reg;
        cap_band         = '0;
        cnt_load         = 1'b0;
        cnt_dec          = 1'b0;

        // Set is evaluated after clear so a simultaneous drop keeps the flag.
        overrun_next = overrun_reg;
        if (ovr_clr) begin
            overrun_next = 1'b0;
        end
        if (sample_valid && (estado_reg != ST_IDLE)) begin
            overrun_next = 1'b1;
        end

        case (estado_reg)
            ST_IDLE: begin
                if (sample_valid) begin
                    uk_next     = adc_data;
                    band_next   = 2'd0;
                    sel_next    = SEL_ALTAS;
                    cnt_load    = 1'b1;
                    busy_next   = 1'b1;
                    estado_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                // The enable is raised on the way into COMMIT so that the
                // registered strobe covers exactly the COMMIT cycle.
                if (cnt_done) begin
                    en_next[band_reg] = 1'b1;
                    estado_next       = ST_COMMIT;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_COMMIT: begin
                // Captured on the same edge the filter's state registers
                // update, so the stored value is the pre-update output.
                cap_band[band_reg] = 1'b1;
                if (band_reg != BAND_LAST) begin
                    band_next   = band_reg + 2'd1;
                    sel_next    = sel_for_band(band_reg + 2'd1);
                    cnt_load    = 1'b1;
                    estado_next = ST_SETTLE;
                end else begin
                    band_next        = 2'd0;
                    sel_next         = SEL_ALTAS;
                    busy_next        = 1'b0;
                    bands_valid_next = 1'b1;
                    estado_next      = ST_IDLE;
                end
            end
            default: begin
                estado_next = ST_IDLE;
            end
        endcase
    end

    // One result register per band, written only in that band's COMMIT cycle.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_band
            logic [Width-1:0] res_reg;
            always_ff @(posedge clk150kHz or posedge reset) begin
                if (reset) begin
                    res_reg <= '0;
                end else if (cap_band[gi]) begin
                    res_reg <= filt_out;
                end
            end
        end
    endgenerate

    assign uk          = uk_reg;
    assign Sel_Muxes   = sel_reg;
    assign enable1     = en_reg[0];
    assign enable2     = en_reg[1];
    assign enable3     = en_reg[2];
    assign band_altas  = g_band[0].res_reg;
    assign band_medias = g_band[1].res_reg;
    assign band_bajas  = g_band[2].res_reg;
    assign bands_valid = bands_valid_reg;
    assign busy        = busy_reg;
    assign overrun     = overrun_reg;

endmodule

// File: tb/tb_secuenciador_bandas_filtro.sv
// -----------------------------------------------------------------------------
// tb_secuenciador_bandas_filtro
// Scoreboard bench: the stimulus process pushes the expected commit events and
// band results for each accepted sample; a monitor on the falling edge pops and
// compares whenever an enable strobe or bands_valid appears. Cycle numbers are
// counted from the acceptance edge (cycle 1 is the first cycle after it).
// A small behavioural three-band filter (first-order low-pass, shifts 1/3/5)
// stands in for the datapath in the last test.
// -----------------------------------------------------------------------------
module tb_secuenciador_bandas_filtro;

    localparam int W = 22;
    localparam int P = 3;   // SettleCycles + 1

    logic         clk150kHz = 1'b0;
    logic         reset = 1'b1;
    logic         sample_valid = 1'b0;
    logic [W-1:0] adc_data = '0;
    logic [W-1:0] filt_out;
    logic         ovr_clr = 1'b0;
    logic [W-1:0] uk;
    logic [1:0]   Sel_Muxes;
    logic         enable1, enable2, enable3;
    logic [W-1:0] band_altas, band_medias, band_bajas;
    logic         bands_valid, busy, overrun;

    secuenciador_bandas_filtro dut (
        .clk150kHz    (clk150kHz),
        .reset        (reset),
        .sample_valid (sample_valid),
        .adc_data     (adc_data),
        .filt_out     (filt_out),
        .ovr_clr      (ovr_clr),
        .uk           (uk),
        .Sel_Muxes    (Sel_Muxes),
        .enable1      (enable1),
        .enable2      (enable2),
        .enable3      (enable3),
        .band_altas   (band_altas),
        .band_medias  (band_medias),
        .band_bajas   (band_bajas),
        .bands_valid  (bands_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk150kHz = ~clk150kHz;

    int cyc = 0;
    always @(posedge clk150kHz) cyc <= cyc + 1;

    // ---------------- behavioural filter datapath ----------------
    int mode = 0;  // 0: constant 7, 1: per-band constants, 2: IIR filter
    logic signed [W-1:0] fs0, fs1, fs2, y0, y1, y2, uks;
    assign uks = $signed(uk);
    assign y0  = fs0 + ((uks - fs0) >>> 1);
    assign y1  = fs1 + ((uks - fs1) >>> 3);
    assign y2  = fs2 + ((uks - fs2) >>> 5);

    always @(posedge clk150kHz or posedge reset) begin
        if (reset) begin
            fs0 <= '0; fs1 <= '0; fs2 <= '0;
        end else begin
            if (enable1) fs0 <= y0;
            if (enable2) fs1 <= y1;
            if (enable3) fs2 <= y2;
        end
    end

    always_comb begin
        filt_out = '0;
        case (mode)
            0: filt_out = 22'sd7;
            1: case (Sel_Muxes)
                   2'b00:   filt_out = -22'sd5;
                   2'b01:   filt_out = 22'sd12;
                   2'b10:   filt_out = -22'sd300;
                   default: filt_out = '0;
               endcase
            default: case (Sel_Muxes)
                   2'b00:   filt_out = y0;
                   2'b01:   filt_out = y1;
                   2'b10:   filt_out = y2;
                   default: filt_out = '0;
               endcase
        endcase
    end

    // ---------------- scoreboard ----------------
    typedef struct { int band; int cyc; int sel; int ukv; } commit_t;
    typedef struct { int a; int m; int b; int cyc; } result_t;

    commit_t exp_commit[$];
    result_t exp_result[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_pass(input int t0, input int u, input int a, input int m,
                             input int b, input int nbands, input bit with_result);
        commit_t c;
        result_t r;
        for (int k = 0; k < nbands; k++) begin
            c.band = k; c.cyc = t0 + (k + 1) * P; c.sel = k; c.ukv = u;
            exp_commit.push_back(c);
        end
        if (with_result) begin
            r.a = a; r.m = m; r.b = b; r.cyc = t0 + 3 * P + 1;
            exp_result.push_back(r);
        end
    endtask

    task automatic issue(input int data);
        sample_valid = 1'b1;
        adc_data     = W'(data);
        @(negedge clk150kHz);
        sample_valid = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk150kHz);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_uk"},          int'($signed(uk)), 0);
        chk({tag, "_sel"},         int'(Sel_Muxes), 0);
        chk({tag, "_enables"},     int'({enable3, enable2, enable1}), 0);
        chk({tag, "_band_altas"},  int'($signed(band_altas)), 0);
        chk({tag, "_band_medias"}, int'($signed(band_medias)), 0);
        chk({tag, "_band_bajas"},  int'($signed(band_bajas)), 0);
        chk({tag, "_bands_valid"}, int'(bands_valid), 0);
        chk({tag, "_busy"},        int'(busy), 0);
        chk({tag, "_overrun"},     int'(overrun), 0);
    endtask

    // Monitor: compares every presented commit and result against the queues.
    always @(negedge clk150kHz) begin : monitor
        commit_t c;
        result_t r;
        if (!reset && (enable1 || enable2 || enable3)) begin
            if (exp_commit.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_commit: enables=%b at cycle %0d, expected none",
                         {enable3, enable2, enable1}, cyc);
            end else begin
                c = exp_commit.pop_front();
                chk("commit_enables", int'({enable3, enable2, enable1}), 1 << c.band);
                chk("commit_cycle",   cyc, c.cyc);
                chk("commit_sel",     int'(Sel_Muxes), c.sel);
                chk("commit_uk",      int'($signed(uk)), c.ukv);
                $display("commit band=%0d cycle=%0d sel=%0d uk=%0d", c.band, cyc,
                         Sel_Muxes, $signed(uk));
            end
        end
        if (!reset && bands_valid) begin
            if (exp_result.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_bands_valid: at cycle %0d, expected none", cyc);
            end else begin
                r = exp_result.pop_front();
                chk("band_altas",  int'($signed(band_altas)),  r.a);
                chk("band_medias", int'($signed(band_medias)), r.m);
                chk("band_bajas",  int'($signed(band_bajas)),  r.b);
                chk("valid_cycle", cyc, r.cyc);
                chk("valid_busy",  int'(busy), 0);
                $display("result cycle=%0d altas=%0d medias=%0d bajas=%0d", cyc,
                         $signed(band_altas), $signed(band_medias), $signed(band_bajas));
            end
        end
        if (Sel_Muxes == 2'b11) begin
            n_cmp++; n_bad++;
            $display("FAIL sel_illegal: Sel_Muxes=11 at cycle %0d, expected 00/01/10", cyc);
        end
    end

    // ---------------- stimulus ----------------
    int t0, t1, t2, t3, t;
    int gs[3];
    int sh[3];

    initial begin
        sh[0] = 1; sh[1] = 3; sh[2] = 5;

        // Reset state.
        repeat (3) @(negedge clk150kHz);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk150kHz);

        // Test 1: constant filter output 7.
        mode = 0;
        t0 = cyc;
        push_pass(t0, 1000, 7, 7, 7, 3, 1'b1);
        issue(1000);
        chk("t1_busy", int'(busy), 1);
        chk("t1_uk", int'($signed(uk)), 1000);
        wait_cyc(t0 + 10);

        // Tests 2+4: new sample in the bands_valid cycle, per-band constants.
        mode = 1;
        t1 = cyc;
        push_pass(t1, -2000, -5, 12, -300, 3, 1'b1);
        issue(-2000);
        chk("t4_busy", int'(busy), 1);
        chk("t4_overrun", int'(overrun), 0);
        chk("t4_uk", int'($signed(uk)), -2000);

        // Test 3: sample while busy is dropped, then cleared.
        wait_cyc(t1 + 5);
        issue(555);
        chk("t3_overrun_set", int'(overrun), 1);
        chk("t3_uk_held", int'($signed(uk)), -2000);
        ovr_clr = 1'b1;
        @(negedge clk150kHz);
        ovr_clr = 1'b0;
        chk("t3_overrun_clr", int'(overrun), 0);

        // Simultaneous drop and clear: set wins.
        wait_cyc(t1 + 8);
        ovr_clr = 1'b1;
        issue(777);
        ovr_clr = 1'b0;
        chk("t3_set_wins", int'(overrun), 1);
        ovr_clr = 1'b1;
        @(negedge clk150kHz);
        ovr_clr = 1'b0;
        chk("t3_overrun_clr2", int'(overrun), 0);
        @(negedge clk150kHz);

        // Test 5: reset during bajas SETTLE aborts the pass.
        t2 = cyc;
        push_pass(t2, 3333, 0, 0, 0, 2, 1'b0);
        issue(3333);
        wait_cyc(t2 + 7);
        reset = 1'b1;
        #1;
        check_all_zero("midrst");
        @(negedge clk150kHz);
        reset = 1'b0;
        @(negedge clk150kHz);
        t3 = cyc;
        push_pass(t3, 4444, -5, 12, -300, 3, 1'b1);
        issue(4444);
        chk("t5_restart_sel", int'(Sel_Muxes), 0);
        wait_cyc(t3 + 10);
        @(negedge clk150kHz);

        // Test 6: step into the behavioural IIR filter, 20 samples back to back.
        reset = 1'b1;
        @(negedge clk150kHz);
        reset = 1'b0;
        @(negedge clk150kHz);
        mode = 2;
        gs[0] = 0; gs[1] = 0; gs[2] = 0;
        for (int n = 0; n < 20; n++) begin
            for (int b = 0; b < 3; b++) gs[b] = gs[b] + ((16384 - gs[b]) >>> sh[b]);
            t = cyc;
            push_pass(t, 16384, gs[0], gs[1], gs[2], 3, 1'b1);
            issue(16384);
            wait_cyc(t + 10);
        end

        // Drain: every expected event must have been seen.
        for (int i = 0; i < 50 && (exp_commit.size() + exp_result.size()) != 0; i++)
            @(negedge clk150kHz);
        chk("queues_drained", exp_commit.size() + exp_result.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
